// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit data memory behind a Req/Ack handshake with WAIT_STATES extra cycles per access
//   clk, resetN          : clock, asynchronous active-low reset
//   Req/Write/Addr/WData : request, direction, word address, write data (sampled only in IDLE)
//   Ack                  : one-cycle completion pulse
//   RData/Err            : read data and out-of-range flag, updated with each Ack and held until the next
//   Busy                 : state is not IDLE
//   ReadCount/WriteCount : saturating in-range access counters, present only with MEM_RESP_STATS_EN
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        Req,
  input  logic        Write,
  input  logic [15:0] Addr,
  input  logic [15:0] WData,
  output logic        Ack,
  output logic [15:0] RData,
  output logic        Err,
  output logic        Busy
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0] ReadCount,
  output logic [15:0] WriteCount
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic take, fire, oor;
  // the _d request fields equal the latched ones in WAIT and the incoming ones at the accepting
  // edge, so a zero-wait access sees exactly the values being latched on that same edge
  always_comb begin
    take = state_q == S_IDLE && Req;
    fire = (take && WAIT_STATES == 0) || (state_q == S_WAIT && cnt_q == 4'd0);
    wr_d = take ? Write : wr_q;
    addr_d = take ? Addr : addr_q;
    wdata_d = take ? WData : wdata_q;
    oor = |(addr_d >> ADDR_W);
    state_d = state_q == S_RESP ? S_IDLE : fire ? S_RESP : take ? S_WAIT : state_q;
    cnt_d = take ? 4'(WAIT_STATES - 1) : state_q == S_WAIT ? cnt_q - 4'd1 : cnt_q;
    err_d = fire ? oor : err_q;
    rdata_d = !fire ? rdata_q : oor ? 16'h0000 : wr_d ? rdata_q : mem[addr_d[ADDR_W-1:0]];
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      wr_q <= 1'b0;
      addr_q <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  // array has no reset; resetN gates the write so a zero-wait request cannot commit during reset
  always_ff @(posedge clk)
    if (resetN && fire && wr_d && !oor) mem[addr_d[ADDR_W-1:0]] <= wdata_d;
  assign Ack = state_q == S_RESP;
  assign Busy = state_q != S_IDLE;
  assign RData = rdata_q;
  assign Err = err_q;
`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      rd_cnt_q <= 16'h0000;
      wr_cnt_q <= 16'h0000;
    end else if (fire && !oor) begin
      if (!wr_d && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_d && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  assign ReadCount = rd_cnt_q;
  assign WriteCount = wr_cnt_q;
`endif
endmodule
